// File: rtl/alu_exec_ctrl.sv
// MIPS-style ALU execute stage: funct decode, single-cycle ALU ops, and a
// multi-cycle shift-add multiplier / restoring divider that commits to HI/LO.
module alu_exec_ctrl #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       instrucao,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       ALUOperation,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             div0,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO
    } op_e;

    state_e               state, state_next;
    op_e                  op;
    logic                 op_illegal;
    logic                 is_mul, is_div, is_signed, accept;
    logic                 div_by_zero, div_ovf;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH-1:0]     sum, diff, alu_res;
    logic                 alu_ovf;

    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic [CW-1:0]        cnt;
    logic                 neg_res, neg_rem, ovf_pend;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_part;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   fix_src, prod;
    logic [WIDTH-1:0]     quot, rem, fix_hi, fix_lo;

    // NOTE: every combinational output gets a default before the case, so no latch is inferred.
    always_comb begin
        op         = OP_AND;
        op_illegal = 1'b0;
        case (ALUOp)
            2'b01: op = OP_SUB;
            2'b10: begin
                case (instrucao)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b101011: op = OP_SLTU;
                    6'b011000: op = OP_MULT;
                    6'b011001: op = OP_MULTU;
                    6'b011010: op = OP_DIV;
                    6'b011011: op = OP_DIVU;
                    6'b010000: op = OP_MFHI;
                    6'b010010: op = OP_MFLO;
                    default:   op_illegal = 1'b1;
                endcase
                if (!MULDIV_EN && (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO})) begin
                    op         = OP_AND;
                    op_illegal = 1'b1;
                end
            end
            default: op = OP_ADD;
        endcase
    end

    always_comb begin
        case (op)
            OP_ADD:  ALUOperation = 4'b0010;
            OP_SUB:  ALUOperation = 4'b0110;
            OP_AND:  ALUOperation = 4'b0000;
            OP_OR:   ALUOperation = 4'b0001;
            OP_XOR:  ALUOperation = 4'b0011;
            OP_NOR:  ALUOperation = 4'b1100;
            OP_SLT:  ALUOperation = 4'b0111;
            OP_SLTU: ALUOperation = 4'b1000;
            default: ALUOperation = 4'b1111;
        endcase
    end

    assign is_mul      = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div      = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_signed   = (op == OP_MULT) || (op == OP_DIV);
    assign in_ready    = (state == IDLE);
    assign accept      = in_valid && in_ready;
    assign div_by_zero = is_div && (op_b == '0);
    assign div_ovf     = (op == OP_DIV) && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
    assign mag_a       = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign mag_b       = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    always_comb begin
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        alu_res = op_a & op_b;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = WIDTH'($signed(op_a) < $signed(op_b));
            OP_SLTU: alu_res = WIDTH'(op_a < op_b);
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = op_a & op_b;
        endcase
    end

    // One iteration of each algorithm; the final iteration is fixed up and committed on the same edge.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        div_part = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = (div_part >= {1'b0, opnd});
        div_rem  = div_part[WIDTH-1:0] - opnd;
        div_next = {(div_ge ? div_rem : div_part[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        fix_src  = (state == DIV) ? div_next : mul_next;
        prod     = neg_res ? -fix_src : fix_src;
        quot     = neg_res ? -fix_src[WIDTH-1:0] : fix_src[WIDTH-1:0];
        rem      = neg_rem ? -fix_src[2*WIDTH-1:WIDTH] : fix_src[2*WIDTH-1:WIDTH];
        fix_hi   = (state == DIV) ? rem  : prod[2*WIDTH-1:WIDTH];
        fix_lo   = (state == DIV) ? quot : prod[WIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) begin
                if (is_mul)           state_next = MUL;
                else if (div_by_zero) state_next = FIX;
                else if (is_div)      state_next = DIV;
            end
            MUL, DIV: if (cnt == '0) state_next = FIX;
            default:  state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FIX is the cycle in which a multi-cycle result is presented with out_valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            div0      <= 1'b0;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            acc       <= '0;
            opnd      <= '0;
            cnt       <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            ovf_pend  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    neg_res  <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    neg_rem  <= is_signed && op_a[WIDTH-1];
                    ovf_pend <= div_ovf;
                    cnt      <= CW'(WIDTH-1);
                    if (is_mul) begin
                        acc  <= {{WIDTH{1'b0}}, mag_b};
                        opnd <= mag_a;
                    end else if (div_by_zero) begin
                        out_valid <= 1'b1;
                        result    <= '1;
                        zero      <= 1'b0;
                        ovf       <= 1'b0;
                        div0      <= 1'b1;
                        illegal   <= 1'b0;
                        hi        <= op_a;
                        lo        <= '1;
                    end else if (is_div) begin
                        acc  <= {{WIDTH{1'b0}}, mag_a};
                        opnd <= mag_b;
                    end else begin
                        out_valid <= 1'b1;
                        result    <= alu_res;
                        zero      <= (alu_res == '0);
                        ovf       <= alu_ovf;
                        div0      <= 1'b0;
                        illegal   <= op_illegal;
                    end
                end
                MUL, DIV: begin
                    acc <= fix_src;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        out_valid <= 1'b1;
                        result    <= fix_lo;
                        zero      <= (fix_lo == '0);
                        ovf       <= ovf_pend;
                        div0      <= 1'b0;
                        illegal   <= 1'b0;
                        hi        <= fix_hi;
                        lo        <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_exec_ctrl;
    localparam int W = 32;
    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -64'sh80000000;

    typedef struct {
        logic [3:0]   aluop;
        logic [W-1:0] result;
        logic         zero, ovf, div0, illegal;
        logic [W-1:0] hi, lo;
        int           lat, rdy_low;
    } exp_t;

    logic         clk, rst_n;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] op_a, op_b;
    logic         in_valid, in_ready, out_valid;
    logic [3:0]   alu_operation;
    logic [W-1:0] result, hi, lo;
    logic         zero, ovf, div0, illegal;

    logic [1:0]   lite_alu_op;
    logic [5:0]   lite_funct;
    logic [W-1:0] lite_a, lite_b;
    logic         lite_valid, lite_ready, lite_out_valid;
    logic [3:0]   lite_alu_operation;
    logic [W-1:0] lite_result, lite_hi, lite_lo;
    logic         lite_zero, lite_ovf, lite_div0, lite_illegal;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;
    logic [5:0] funct_tab [14] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                   6'b100111, 6'b101010, 6'b101011, 6'b010000, 6'b010010,
                                   6'b011000, 6'b011001, 6'b011010, 6'b011011};

    alu_exec_ctrl #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(alu_op), .instrucao(funct),
        .op_a(op_a), .op_b(op_b), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOperation(alu_operation), .out_valid(out_valid), .result(result),
        .zero(zero), .ovf(ovf), .div0(div0), .illegal(illegal), .hi(hi), .lo(lo)
    );

    alu_exec_ctrl #(.WIDTH(W), .MULDIV_EN(1'b0)) dut_lite (
        .clk(clk), .rst_n(rst_n), .ALUOp(lite_alu_op), .instrucao(lite_funct),
        .op_a(lite_a), .op_b(lite_b), .in_valid(lite_valid), .in_ready(lite_ready),
        .ALUOperation(lite_alu_operation), .out_valid(lite_out_valid), .result(lite_result),
        .zero(lite_zero), .ovf(lite_ovf), .div0(lite_div0), .illegal(lite_illegal),
        .hi(lite_hi), .lo(lite_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: arithmetic straight from the instruction semantics.
    function automatic exp_t model(input logic [1:0] aop, input logic [5:0] f,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] hm, input logic [W-1:0] lm, input bit en);
        exp_t        e;
        string       k;
        longint      sa, sb, s;
        logic [63:0] p, q, r;
        e.hi = hm; e.lo = lm; e.ovf = 1'b0; e.div0 = 1'b0; e.illegal = 1'b0;
        e.lat = 1; e.rdy_low = 0; e.aluop = 4'b1111; e.result = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (aop != 2'b10) k = (aop == 2'b01) ? "sub" : "add";
        else begin
            case (f)
                6'b100000: k = "add";   6'b100010: k = "sub";
                6'b100100: k = "and";   6'b100101: k = "or";
                6'b100110: k = "xor";   6'b100111: k = "nor";
                6'b101010: k = "slt";   6'b101011: k = "sltu";
                6'b011000: k = "mult";  6'b011001: k = "multu";
                6'b011010: k = "div";   6'b011011: k = "divu";
                6'b010000: k = "mfhi";  6'b010010: k = "mflo";
                default:   k = "bad";
            endcase
        end
        if (!en && (k == "mult" || k == "multu" || k == "div" || k == "divu" || k == "mfhi" || k == "mflo"))
            k = "bad";
        case (k)
            "add":  begin s = sa + sb; e.result = a + b; e.ovf = (s > SMAX) || (s < SMIN); e.aluop = 4'b0010; end
            "sub":  begin s = sa - sb; e.result = a - b; e.ovf = (s > SMAX) || (s < SMIN); e.aluop = 4'b0110; end
            "and":  begin e.result = a & b;    e.aluop = 4'b0000; end
            "or":   begin e.result = a | b;    e.aluop = 4'b0001; end
            "xor":  begin e.result = a ^ b;    e.aluop = 4'b0011; end
            "nor":  begin e.result = ~(a | b); e.aluop = 4'b1100; end
            "slt":  begin e.result = (sa < sb) ? 32'd1 : 32'd0; e.aluop = 4'b0111; end
            "sltu": begin e.result = (a < b)   ? 32'd1 : 32'd0; e.aluop = 4'b1000; end
            "bad":  begin e.result = a & b; e.illegal = 1'b1; e.aluop = 4'b0000; end
            "mfhi": e.result = hm;
            "mflo": e.result = lm;
            "mult", "multu": begin
                if (k == "mult") p = sa * sb;
                else             p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32]; e.lo = p[31:0];
                e.lat = W + 1; e.rdy_low = W + 1;
            end
            default: begin
                if (b == '0) begin
                    e.hi = a; e.lo = '1; e.div0 = 1'b1; e.rdy_low = 1;
                end else begin
                    e.lat = W + 1; e.rdy_low = W + 1;
                    if (k == "div" && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                        e.lo = 32'h80000000; e.hi = '0; e.ovf = 1'b1;
                    end else if (k == "div") begin
                        q = sa / sb; r = sa % sb;
                        e.lo = q[31:0]; e.hi = r[31:0];
                    end else begin
                        e.lo = a / b; e.hi = a % b;
                    end
                end
            end
        endcase
        if (k inside {"mult", "multu", "div", "divu"}) e.result = e.lo;
        e.zero = (e.result == '0);
        return e;
    endfunction

    task automatic run_op(input logic [1:0] aop, input logic [5:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        exp_t e;
        int   n, low;
        e = model(aop, f, a, b, hi_m, lo_m, 1'b1);
        @(negedge clk);
        alu_op = aop; funct = f; op_a = a; op_b = b; in_valid = 1'b1;
        #1;
        check({tag, ".aluop"}, alu_operation, e.aluop);
        check({tag, ".ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1; low = 0;
        if (in_ready !== 1'b1) low++;
        while (out_valid !== 1'b1 && n < e.lat + 8) begin
            @(negedge clk);
            n++;
            if (in_ready !== 1'b1) low++;
        end
        check({tag, ".latency"}, n, e.lat);
        check({tag, ".busy"}, low, e.rdy_low);
        check({tag, ".result"}, result, e.result);
        check({tag, ".zero"}, zero, e.zero);
        check({tag, ".ovf"}, ovf, e.ovf);
        check({tag, ".div0"}, div0, e.div0);
        check({tag, ".illegal"}, illegal, e.illegal);
        check({tag, ".hi"}, hi, e.hi);
        check({tag, ".lo"}, lo, e.lo);
        hi_m = e.hi; lo_m = e.lo;
        @(negedge clk);
        check({tag, ".pulse"}, out_valid, 0);
        check({tag, ".idle"}, in_ready, 1);
    endtask

    task automatic run_burst(input int len);
        exp_t       q[$];
        exp_t       e;
        logic [5:0] f;
        logic [W-1:0] a, b;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = q.pop_front();
                check("burst.valid", out_valid, 1);
                check("burst.result", result, e.result);
                check("burst.ovf", ovf, e.ovf);
                check("burst.zero", zero, e.zero);
            end
            f = funct_tab[$urandom_range(0, 9)];
            a = $urandom(); b = $urandom();
            alu_op = 2'b10; funct = f; op_a = a; op_b = b; in_valid = 1'b1;
            q.push_back(model(2'b10, f, a, b, hi_m, lo_m, 1'b1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        e = q.pop_front();
        check("burst.valid", out_valid, 1);
        check("burst.result", result, e.result);
        @(negedge clk);
        check("burst.end", out_valid, 0);
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'h7FFFFFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        exp_t       e;
        int         seen;
        logic [1:0] aop;
        logic [5:0] f;

        rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; funct = '0; op_a = '0; op_b = '0;
        lite_alu_op = '0; lite_funct = '0; lite_a = '0; lite_b = '0; lite_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.out_valid", out_valid, 0);
        check("rst.result", result, 0);
        check("rst.flags", {zero, ovf, div0, illegal}, 0);
        check("rst.hi", hi, 0);
        check("rst.lo", lo, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.ready", in_ready, 1);

        run_op(2'b10, 6'b100000, 32'd7, 32'd5, "add7_5");
        run_op(2'b10, 6'b100000, 32'h7FFFFFFF, 32'd1, "add_ovf");
        run_op(2'b10, 6'b100010, 32'h80000000, 32'd1, "sub_ovf");
        run_op(2'b10, 6'b100010, 32'd9, 32'd9, "sub_zero");
        run_op(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, "slt");
        run_op(2'b10, 6'b101011, 32'hFFFFFFFF, 32'd1, "sltu");
        run_op(2'b10, 6'b100111, 32'h0F0F0000, 32'h00000F0F, "nor");
        run_op(2'b00, 6'b100010, 32'd100, 32'd23, "aluop00");
        run_op(2'b01, 6'b100000, 32'd100, 32'd23, "aluop01");
        run_op(2'b11, 6'b101010, 32'hFFFFFFFF, 32'd2, "aluop11");
        run_op(2'b10, 6'b111111, 32'hF0, 32'h3C, "bad_funct");
        run_op(2'b10, 6'b011000, 32'hFFFFFFFD, 32'd5, "mult");
        run_op(2'b10, 6'b010000, 32'd0, 32'd0, "mfhi");
        run_op(2'b10, 6'b010010, 32'd0, 32'd0, "mflo");
        run_op(2'b10, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu");
        run_op(2'b10, 6'b011011, 32'd100, 32'd7, "divu");
        run_op(2'b10, 6'b011010, 32'hFFFFFFF9, 32'd2, "div_neg");
        run_op(2'b10, 6'b011010, 32'd9, 32'd0, "div0");
        run_op(2'b10, 6'b011010, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_burst(6);

        run_op(2'b10, 6'b011000, 32'hFFFFFFFD, 32'd5, "pre_abort");
        @(negedge clk);
        alu_op = 2'b10; funct = 6'b011000; op_a = 32'h12345; op_b = 32'h777; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort.valid", out_valid, 0);
        check("abort.hi", hi, 0);
        check("abort.lo", lo, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort.ready", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check("abort.no_result", seen, 0);
        hi_m = '0; lo_m = '0;

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0:       aop = 2'b00;
                1:       aop = 2'b01;
                2:       aop = 2'b11;
                default: aop = 2'b10;
            endcase
            if ($urandom_range(0, 16) < 14) f = funct_tab[$urandom_range(0, 13)];
            else                            f = 6'($urandom());
            run_op(aop, f, rand_val(), rand_val(), $sformatf("rand%0d", i));
        end

        @(negedge clk);
        lite_alu_op = 2'b10; lite_funct = 6'b011000; lite_a = 32'hF0; lite_b = 32'h3C; lite_valid = 1'b1;
        e = model(2'b10, 6'b011000, 32'hF0, 32'h3C, '0, '0, 1'b0);
        #1;
        check("lite.aluop", lite_alu_operation, e.aluop);
        @(negedge clk);
        lite_valid = 1'b0;
        check("lite.valid", lite_out_valid, 1);
        check("lite.result", lite_result, e.result);
        check("lite.illegal", lite_illegal, e.illegal);
        check("lite.hi", lite_hi, 0);
        @(negedge clk);
        check("lite.pulse", lite_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal range 8..64.
REQ-002 Parameter MULDIV_EN, default 1; 1 enables mult/multu/div/divu/mfhi/mflo, 0 removes them.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 ALUOp  input  2  main-control op class: 00 load/store, 01 branch, 10 R-type, 11 immediate.
REQ-006 instrucao  input  6  funct field, used only when ALUOp=10.
REQ-007 op_a, op_b  input  WIDTH each  operands (rs, rt/imm).
REQ-008 in_valid / in_ready  input / output  1 each  issue handshake; transfer when both are high on a rising edge.
REQ-009 ALUOperation  output  4  combinational decode of the current inputs (0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 0011 xor, 1100 nor, 1000 sltu, 1111 mul/div/move).
REQ-010 out_valid  output  1  one-cycle pulse marking a valid result; no backpressure.
REQ-011 result  output  WIDTH  registered result, held until the next out_valid.
REQ-012 zero, ovf, div0, illegal  output  1 each  registered flags, updated together with out_valid.
REQ-013 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-014 Decode: ALUOp 00 and 11 give add; 01 gives sub.
REQ-015 ALUOp=10 funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 101011 sltu, 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo.
REQ-016 Unknown funct, or any mul/div/move funct when MULDIV_EN=0: ALUOperation=0000, and is executed, and illegal=1 on that result.
REQ-017 FSM states are IDLE, MUL, DIV, FIX; in_ready=1 only in IDLE.
REQ-018 Simple ops (add/sub/logic/slt/sltu/mfhi/mflo) stay in IDLE; out_valid is asserted the cycle after acceptance (latency 1), so back-to-back issue gives one result per cycle.
REQ-019 add/sub wrap modulo 2^WIDTH; ovf=1 on signed overflow, 0 for all other ops.
REQ-020 slt compares signed and sltu compares unsigned; the result is 1 or 0, zero-extended.
REQ-021 zero=1 iff result==0, for every op.
REQ-022 mult/multu: IDLE->MUL; shift-add runs on operand magnitudes (signed for mult) for exactly WIDTH cycles; MUL->FIX; FIX applies sign, writes hi=upper and lo=lower product half, pulses out_valid with result=lo, and returns to IDLE.
REQ-023 mult/multu latency: out_valid is high WIDTH+1 cycles after acceptance.
REQ-024 div/divu: IDLE->DIV; restoring division runs for WIDTH cycles, then FIX. lo=quotient, truncated toward zero. hi=remainder, with the sign of the dividend. result=lo. Latency WIDTH+1.
REQ-025 Divide by zero (op_b==0): skip DIV and go to FIX directly (latency 1). hi=op_a, lo=all ones, div0=1.
REQ-026 Signed div of most-negative by -1 gives lo=most-negative, hi=0, ovf=1.
REQ-027 hi/lo change only in FIX; mfhi/mflo read the values committed before their acceptance.
REQ-028 in_valid while in_ready=0 is ignored; no queueing; the issuer must hold the request.
REQ-029 ALUOperation is purely combinational from ALUOp/instrucao, independent of FSM state.

Reset
REQ-030 When rst_n=0 at a rising edge: state=IDLE; out_valid, zero, ovf, div0, illegal=0; result, hi, lo=0; iteration counter=0.
REQ-031 Reset asserted mid-MUL/DIV aborts the operation: no out_valid, and hi/lo are cleared; in_ready=1 on the first cycle after rst_n returns high.

Verification
REQ-032 WIDTH=32, ALUOp=10, funct 100000, a=7, b=5 -> next cycle out_valid=1, result=12, zero=0, ovf=0.
REQ-033 add 0x7FFFFFFF+1 -> result 0x80000000, ovf=1; slt a=0xFFFFFFFF b=1 -> 1; sltu same operands -> 0.
REQ-034 mult a=-3 b=5 -> in_ready low for 33 cycles, out_valid 33 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFF1; then mfhi -> 0xFFFFFFFF.
REQ-035 divu 100/7 -> lo=14, hi=2 after 33 cycles; div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div a=9 b=0 -> 1-cycle, div0=1, hi=9, lo=0xFFFFFFFF.
REQ-036 Assert rst_n=0 at cycle 10 of a mult -> no out_valid, hi=lo=0, in_ready=1 on the first cycle after release.
REQ-037 MULDIV_EN=0, funct 011000, a=0xF0 b=0x3C -> ALUOperation=0000, result=0x30, illegal=1, latency 1.
